// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the UART program loader
//
// Purpose: loader FSM state encoding and err_code values.
// Ports:   none (package).

package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_DATA   = 3'd2,
      ST_CSUM   = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } loader_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs a byte stream into WORD_BYTES-wide words
//
// Purpose: places each accepted byte into its lane of the word and flags the
//          cycle in which the final byte of a word arrives.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear_i         restart at byte 0 and zero the partial word
//   byte_valid_i    byte_i is accepted this cycle
//   byte_i          incoming byte
//   word_valid_o    final byte of a word accepted this cycle (combinational)
//   word_o          assembled word including the byte accepted this cycle

module word_assembler #(
   parameter int WORD_BYTES = 4,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear_i,
   input  logic                    byte_valid_i,
   input  logic [7:0]              byte_i,
   output logic                    word_valid_o,
   output logic [8*WORD_BYTES-1:0] word_o
);

   localparam int WORD_W = 8 * WORD_BYTES;
   localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

   logic [WORD_W-1:0] word_q, word_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   int                shift;

   always_comb begin
      // Lane 0 is the first byte; big-endian puts lane 0 at the top of the word.
      shift        = BIG_ENDIAN ? 8 * (WORD_BYTES - 1 - int'(idx_q)) : 8 * int'(idx_q);
      word_d       = word_q;
      idx_d        = idx_q;
      word_valid_o = 1'b0;
      if (byte_valid_i) begin
         word_d = (word_q & ~(WORD_W'(8'hFF) << shift)) | (WORD_W'(byte_i) << shift);
         if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            word_valid_o = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
      word_o = word_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (clear_i) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - framed UART image loader into instruction memory
//
// Purpose: parses <len lo><len hi><payload words><sum8> from the receiver
//          byte stream, writes each assembled word to memory and reports
//          done or a coded error.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_data         received byte, valid when rx_valid is high
//   rx_valid        one-cycle byte strobe
//   clr             synchronous return to IDLE, clears done/error/count
//   wr_en           one-cycle memory write strobe
//   wr_addr         word address of the write
//   wr_data         assembled word
//   busy            frame in progress (LEN_HI, DATA, CSUM)
//   load_done       sticky, frame ended with a good checksum
//   load_err        sticky, frame aborted; err_code says why
//   err_code        00 none, 01 length, 10 checksum, 11 timeout
//   words_loaded    words written in the current frame

module uart_prog_loader
   import loader_pkg::*;
#(
   parameter int WORD_BYTES     = 4,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter bit BIG_ENDIAN     = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   input  logic                    clr,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [8*WORD_BYTES-1:0] wr_data,
   output logic                    busy,
   output logic                    load_done,
   output logic                    load_err,
   output logic [1:0]              err_code,
   output logic [ADDR_W:0]         words_loaded
);

   localparam int WORD_W = 8 * WORD_BYTES;
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
   localparam logic [16:0]     MAX_LEN = 17'd1 << ADDR_W;

   loader_state_t     state_q, state_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [7:0]        len_lo_q;
   logic [15:0]       len_q;
   logic [15:0]       len_full;
   logic [ADDR_W:0]   words_q;
   logic [7:0]        csum_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [WORD_W-1:0] wr_data_q;

   logic              byte_in_data;
   logic              asm_valid;
   logic [WORD_W-1:0] asm_word;
   logic              last_word;
   logic              timed_out;

   assign len_full     = {rx_data, len_lo_q};
   assign byte_in_data = rx_valid && !clr && (state_q == ST_DATA);
   assign last_word    = asm_valid && ((17'(words_q) + 17'd1) == {1'b0, len_q});
   // Counter holds clocks elapsed since the last byte minus one, so the
   // T-th silent clock is the one that trips; a strobe in it still wins.
   assign timed_out    = busy && !rx_valid && (to_cnt_q >= TO_LAST);

   word_assembler #(
      .WORD_BYTES (WORD_BYTES),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (clr || (state_q != ST_DATA)),
      .byte_valid_i (byte_in_data),
      .byte_i       (rx_data),
      .word_valid_o (asm_valid),
      .word_o       (asm_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         err_code_q <= err_code_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      err_code_d = err_code_q;
      if (clr) begin
         state_d    = ST_IDLE;
         err_code_d = ERR_NONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_valid) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               if (rx_valid) begin
                  if ({1'b0, len_full} > MAX_LEN) begin
                     state_d    = ST_ERR;
                     err_code_d = ERR_LEN;
                  end else if (len_full == 16'd0) begin
                     state_d = ST_CSUM;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else if (timed_out) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_TIMEOUT;
               end
            end
            ST_DATA: begin
               if (last_word) begin
                  state_d = ST_CSUM;
               end else if (timed_out) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_TIMEOUT;
               end
            end
            ST_CSUM: begin
               if (rx_valid) begin
                  if (rx_data == csum_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d    = ST_ERR;
                     err_code_d = ERR_CSUM;
                  end
               end else if (timed_out) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q == ST_LEN_HI) || (state_q == ST_DATA) || (state_q == ST_CSUM);
      load_done = (state_q == ST_DONE);
      load_err  = (state_q == ST_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_lo_q  <= '0;
         len_q     <= '0;
         words_q   <= '0;
         csum_q    <= '0;
         to_cnt_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (clr) begin
            words_q  <= '0;
            csum_q   <= '0;
            to_cnt_q <= '0;
         end else begin
            if ((state_q == ST_IDLE) && rx_valid) len_lo_q <= rx_data;
            if ((state_q == ST_LEN_HI) && rx_valid) len_q <= len_full;
            if (byte_in_data) csum_q <= csum_q + rx_data;
            if (asm_valid) begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= words_q[ADDR_W-1:0];
               wr_data_q <= asm_word;
               words_q   <= words_q + 1'b1;
            end
            if (!busy || rx_valid) begin
               to_cnt_q <= '0;
            end else if (to_cnt_q != TO_MAX) begin
               to_cnt_q <= to_cnt_q + 1'b1;
            end
         end
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign err_code     = err_code_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - scoreboard bench for uart_prog_loader

module tb_uart_prog_loader;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk;
   int   n_checks = 0;
   int   n_errors = 0;
   wr_t  qa[$];
   wr_t  qb[$];

   logic        rst_n_a, rx_valid_a, clr_a;
   logic [7:0]  rx_data_a;
   logic        wr_en_a, busy_a, load_done_a, load_err_a;
   logic [7:0]  wr_addr_a;
   logic [31:0] wr_data_a;
   logic [1:0]  err_code_a;
   logic [8:0]  words_loaded_a;

   logic        rst_n_b, rx_valid_b, clr_b;
   logic [7:0]  rx_data_b;
   logic        wr_en_b, busy_b, load_done_b, load_err_b;
   logic [7:0]  wr_addr_b;
   logic [15:0] wr_data_b;
   logic [1:0]  err_code_b;
   logic [8:0]  words_loaded_b;

   uart_prog_loader #(
      .WORD_BYTES(4), .ADDR_W(8), .TIMEOUT_CYCLES(16), .BIG_ENDIAN(1'b0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
      .clr(clr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .busy(busy_a), .load_done(load_done_a), .load_err(load_err_a),
      .err_code(err_code_a), .words_loaded(words_loaded_a)
   );

   uart_prog_loader #(
      .WORD_BYTES(2), .ADDR_W(8), .TIMEOUT_CYCLES(16), .BIG_ENDIAN(1'b1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
      .clr(clr_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .busy(busy_b), .load_done(load_done_b), .load_err(load_err_b),
      .err_code(err_code_b), .words_loaded(words_loaded_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write monitors: every write must match the oldest expected write.
   always @(negedge clk) begin
      if (wr_en_a === 1'b1) begin
         if (qa.size() == 0) begin
            check_eq("unexpected_wr_a", 64'(wr_en_a), 64'd0);
         end else begin
            wr_t e;
            e = qa.pop_front();
            check_eq("wr_addr_a", 64'(wr_addr_a), 64'(e.addr));
            check_eq("wr_data_a", 64'(wr_data_a), 64'(e.data));
         end
      end
      if (wr_en_b === 1'b1) begin
         if (qb.size() == 0) begin
            check_eq("unexpected_wr_b", 64'(wr_en_b), 64'd0);
         end else begin
            wr_t e;
            e = qb.pop_front();
            check_eq("wr_addr_b", 64'(wr_addr_b), 64'(e.addr));
            check_eq("wr_data_b", 64'(wr_data_b), 64'(e.data[15:0]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input int sel, input logic [7:0] b);
      if (sel == 0) begin
         rx_data_a  = b;
         rx_valid_a = 1'b1;
      end else begin
         rx_data_b  = b;
         rx_valid_b = 1'b1;
      end
      step();
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
   endtask

   task automatic pulse_clr(input int sel);
      if (sel == 0) clr_a = 1'b1;
      else          clr_b = 1'b1;
      step();
      clr_a = 1'b0;
      clr_b = 1'b0;
   endtask

   task automatic send_good_a(input logic [7:0] cs);
      logic [7:0] fr [10];
      fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
      qa.push_back('{16'd0, 32'h00500013});
      qa.push_back('{16'd1, 32'h00A00093});
      foreach (fr[i]) send_byte(0, fr[i]);
      send_byte(0, cs);
   endtask

   task automatic send_b_1234();
      qb.push_back('{16'd0, 32'h00001234});
      send_byte(1, 8'h01);
      send_byte(1, 8'h00);
      send_byte(1, 8'h12);
      send_byte(1, 8'h34);
      send_byte(1, 8'h46);
   endtask

   initial begin
      logic [31:0] w;
      logic [7:0]  cs;
      logic [7:0]  iv;

      rst_n_a = 1'b0; rst_n_b = 1'b0;
      rx_data_a = '0; rx_valid_a = 1'b0; clr_a = 1'b0;
      rx_data_b = '0; rx_valid_b = 1'b0; clr_b = 1'b0;
      repeat (3) step();

      check_eq("rst_wr_en", 64'(wr_en_a), 64'd0);
      check_eq("rst_wr_addr", 64'(wr_addr_a), 64'd0);
      check_eq("rst_wr_data", 64'(wr_data_a), 64'd0);
      check_eq("rst_busy", 64'(busy_a), 64'd0);
      check_eq("rst_done", 64'(load_done_a), 64'd0);
      check_eq("rst_err", 64'(load_err_a), 64'd0);
      check_eq("rst_code", 64'(err_code_a), 64'd0);
      check_eq("rst_words", 64'(words_loaded_a), 64'd0);

      rst_n_a = 1'b1; rst_n_b = 1'b1;
      step();

      // Good frame
      send_good_a(8'h96);
      check_eq("good_done", 64'(load_done_a), 64'd1);
      check_eq("good_err", 64'(load_err_a), 64'd0);
      check_eq("good_code", 64'(err_code_a), 64'd0);
      check_eq("good_words", 64'(words_loaded_a), 64'd2);
      check_eq("good_busy", 64'(busy_a), 64'd0);
      check_eq("good_pending", 64'(qa.size()), 64'd0);

      pulse_clr(0);
      check_eq("clr_done", 64'(load_done_a), 64'd0);
      check_eq("clr_words", 64'(words_loaded_a), 64'd0);

      // Bad checksum: writes still happen
      send_good_a(8'h97);
      check_eq("badcs_err", 64'(load_err_a), 64'd1);
      check_eq("badcs_code", 64'(err_code_a), 64'd2);
      check_eq("badcs_done", 64'(load_done_a), 64'd0);
      check_eq("badcs_words", 64'(words_loaded_a), 64'd2);

      // Empty frame, then a normal frame after clr
      pulse_clr(0);
      send_byte(0, 8'h00);
      send_byte(0, 8'h00);
      send_byte(0, 8'h00);
      check_eq("empty_done", 64'(load_done_a), 64'd1);
      check_eq("empty_words", 64'(words_loaded_a), 64'd0);
      pulse_clr(0);
      send_good_a(8'h96);
      check_eq("reload_done", 64'(load_done_a), 64'd1);

      // Length error, len 257
      pulse_clr(0);
      send_byte(0, 8'h01);
      send_byte(0, 8'h01);
      check_eq("lenerr_err", 64'(load_err_a), 64'd1);
      check_eq("lenerr_code", 64'(err_code_a), 64'd1);
      check_eq("lenerr_busy", 64'(busy_a), 64'd0);

      // Maximum length, len 256
      pulse_clr(0);
      send_byte(0, 8'h00);
      send_byte(0, 8'h01);
      cs = 8'h00;
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         w  = {iv ^ 8'hA5, iv * 8'd3, ~iv, iv};
         qa.push_back('{16'(i), w});
         for (int k = 0; k < 4; k++) begin
            cs = cs + w[8*k +: 8];
            send_byte(0, w[8*k +: 8]);
         end
      end
      send_byte(0, cs);
      check_eq("max_done", 64'(load_done_a), 64'd1);
      check_eq("max_words", 64'(words_loaded_a), 64'd256);
      check_eq("max_last_addr", 64'(wr_addr_a), 64'd255);

      // clr beats a simultaneous byte; idle does not time out
      pulse_clr(0);
      rx_data_a  = 8'h01;
      rx_valid_a = 1'b1;
      clr_a      = 1'b1;
      step();
      rx_valid_a = 1'b0;
      clr_a      = 1'b0;
      check_eq("clr_drop_busy", 64'(busy_a), 64'd0);
      repeat (30) step();
      check_eq("idle_no_timeout", 64'(load_err_a), 64'd0);

      // Timeout after silence
      send_byte(0, 8'h01);
      send_byte(0, 8'h00);
      send_byte(0, 8'h13);
      send_byte(0, 8'h00);
      send_byte(0, 8'h50);
      repeat (15) step();
      check_eq("to_at_16", 64'(load_err_a), 64'd0);
      step();
      check_eq("to_at_17_err", 64'(load_err_a), 64'd1);
      check_eq("to_at_17_code", 64'(err_code_a), 64'd3);

      // Next byte exactly at the last allowed cycle
      pulse_clr(0);
      qa.push_back('{16'd0, 32'h00500013});
      send_byte(0, 8'h01);
      send_byte(0, 8'h00);
      send_byte(0, 8'h13);
      send_byte(0, 8'h00);
      send_byte(0, 8'h50);
      repeat (15) step();
      send_byte(0, 8'h00);
      check_eq("late_ok_err", 64'(load_err_a), 64'd0);
      check_eq("late_ok_busy", 64'(busy_a), 64'd1);
      send_byte(0, 8'h63);
      check_eq("late_ok_done", 64'(load_done_a), 64'd1);

      // clr mid-frame aborts without error, next frame loads cleanly
      pulse_clr(0);
      send_byte(0, 8'h02);
      send_byte(0, 8'h00);
      send_byte(0, 8'h13);
      pulse_clr(0);
      check_eq("abort_err", 64'(load_err_a), 64'd0);
      check_eq("abort_busy", 64'(busy_a), 64'd0);
      send_good_a(8'h96);
      check_eq("after_abort_done", 64'(load_done_a), 64'd1);

      // Big-endian, 2-byte words
      send_b_1234();
      check_eq("be_done", 64'(load_done_b), 64'd1);
      check_eq("be_words", 64'(words_loaded_b), 64'd1);

      // Asynchronous reset mid-payload
      pulse_clr(1);
      qb.push_back('{16'd0, 32'h0000AABB});
      send_byte(1, 8'h02);
      send_byte(1, 8'h00);
      send_byte(1, 8'hAA);
      send_byte(1, 8'hBB);
      send_byte(1, 8'hCC);
      check_eq("pre_rst_busy", 64'(busy_b), 64'd1);
      rst_n_b = 1'b0;
      #1;
      check_eq("arst_busy", 64'(busy_b), 64'd0);
      check_eq("arst_words", 64'(words_loaded_b), 64'd0);
      check_eq("arst_wr_data", 64'(wr_data_b), 64'd0);
      check_eq("arst_wr_addr", 64'(wr_addr_b), 64'd0);
      check_eq("arst_wr_en", 64'(wr_en_b), 64'd0);
      check_eq("arst_done", 64'(load_done_b), 64'd0);
      check_eq("arst_err", 64'(load_err_b), 64'd0);
      step();
      rst_n_b = 1'b1;
      step();
      send_b_1234();
      check_eq("post_rst_done", 64'(load_done_b), 64'd1);
      check_eq("post_rst_addr", 64'(wr_addr_b), 64'd0);

      step();
      check_eq("qa_drained", 64'(qa.size()), 64'd0);
      check_eq("qb_drained", 64'(qb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
